// File: rtl/valid_ram_ctrl_if.sv
// valid_ram_ctrl_if: groups the requester handshakes and the 2W/1R
// valid-bit RAM bus of valid_ram_ctrl.
//   slave  - the controller side (valid_ram_ctrl).
//   master - the environment side (requesters and RAM).
// Signals:
//   flush_req/flush_busy          invalidate-all sweep request / status
//   rf_req/rf_addr/rf_ack         refill (set valid)
//   inv_req/inv_addr/inv_ack      snoop invalidate (clear valid)
//   lk_req/lk_addr/lk_ack         lookup request
//   lk_rvalid/lk_bit              lookup result
//   W_*_A, W_*_B, R_*_A, R_data_A RAM ports
interface valid_ram_ctrl_if #(
    parameter int DEEPTH = 8
);
    logic              flush_req;
    logic              flush_busy;
    logic              rf_req;
    logic [DEEPTH-1:0] rf_addr;
    logic              rf_ack;
    logic              inv_req;
    logic [DEEPTH-1:0] inv_addr;
    logic              inv_ack;
    logic              lk_req;
    logic [DEEPTH-1:0] lk_addr;
    logic              lk_ack;
    logic              lk_rvalid;
    logic              lk_bit;
    logic [DEEPTH-1:0] W_addr_A;
    logic [DEEPTH-1:0] W_addr_B;
    logic [DEEPTH-1:0] R_addr_A;
    logic              W_data_A;
    logic              W_data_B;
    logic              W_en_A;
    logic              W_en_B;
    logic              R_en_A;
    logic              R_data_A;

    modport slave (
        input  flush_req, rf_req, rf_addr, inv_req, inv_addr, lk_req, lk_addr, R_data_A,
        output flush_busy, rf_ack, inv_ack, lk_ack, lk_rvalid, lk_bit,
               W_addr_A, W_addr_B, R_addr_A, W_data_A, W_data_B, W_en_A, W_en_B, R_en_A
    );

    modport master (
        output flush_req, rf_req, rf_addr, inv_req, inv_addr, lk_req, lk_addr, R_data_A,
        input  flush_busy, rf_ack, inv_ack, lk_ack, lk_rvalid, lk_bit,
               W_addr_A, W_addr_B, R_addr_A, W_data_A, W_data_B, W_en_A, W_en_B, R_en_A
    );
endinterface

// File: rtl/valid_ram_ctrl.sv
// valid_ram_ctrl: controller/arbiter in front of the 2-write/1-read cache
// valid-bit RAM (2^DEEPTH one-bit entries).
//   - Runs a two-port invalidate-all sweep after reset and on flush_req:
//     port A clears the lower half, port B the upper half, 2^(DEEPTH-1) cycles.
//   - In IDLE, port A carries refills (data 1), port B invalidates (data 0).
//   - Lookups go to the read port; result returned one cycle later.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset (forces the sweep, RAM enables off)
//   bus    valid_ram_ctrl_if.slave (requests, acks, RAM bus)
// Requires DEEPTH >= 2.
module valid_ram_ctrl #(
    parameter int DEEPTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    valid_ram_ctrl_if.slave bus
);
    typedef enum logic {
        FLUSH = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [DEEPTH-2:0] r_cnt;
    logic [DEEPTH-2:0] w_cnt_next;
    logic              r_lk_rvalid;

    logic              w_conflict;
    logic              w_en_a;
    logic              w_en_b;
    logic              w_ren;
    logic [DEEPTH-1:0] w_addr_a;
    logic [DEEPTH-1:0] w_addr_b;
    logic              w_data_a;
    logic              w_rf_ack;
    logic              w_inv_ack;

    // Refill and invalidate to the same line: the RAM would drop port B,
    // so the invalidate is moved onto port A instead.
    assign w_conflict = bus.rf_req & bus.inv_req & (bus.rf_addr == bus.inv_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= FLUSH;
            r_cnt       <= '0;
            r_lk_rvalid <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= w_cnt_next;
            r_lk_rvalid <= bus.lk_ack;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_en_a       = 1'b0;
        w_en_b       = 1'b0;
        w_ren        = 1'b0;
        w_addr_a     = '0;
        w_addr_b     = '0;
        w_data_a     = 1'b0;
        w_rf_ack     = 1'b0;
        w_inv_ack    = 1'b0;
        case (r_state)
            FLUSH: begin
                w_en_a     = 1'b1;
                w_addr_a   = {1'b0, r_cnt};
                w_en_b     = 1'b1;
                w_addr_b   = {1'b1, r_cnt};
                // Invalidates are redundant while every line is being cleared.
                w_inv_ack  = bus.inv_req;
                w_cnt_next = r_cnt + 1'b1;
                if (&r_cnt) begin
                    w_next_state = IDLE;
                end
            end
            IDLE: begin
                w_cnt_next = '0;
                w_en_a     = bus.rf_req;
                w_addr_a   = bus.rf_addr;
                w_data_a   = ~w_conflict;
                w_en_b     = bus.inv_req & ~w_conflict;
                w_addr_b   = bus.inv_addr;
                w_rf_ack   = bus.rf_req;
                w_inv_ack  = bus.inv_req;
                w_ren      = bus.lk_req;
                if (bus.flush_req) begin
                    w_next_state = FLUSH;
                end
            end
            default: begin
                w_next_state = FLUSH;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Enables are forced low combinationally while reset is asserted.
    assign bus.W_en_A     = w_en_a & rst_n;
    assign bus.W_en_B     = w_en_b & rst_n;
    assign bus.R_en_A     = w_ren & rst_n;
    assign bus.W_addr_A   = w_addr_a;
    assign bus.W_addr_B   = w_addr_b;
    assign bus.W_data_A   = w_data_a;
    assign bus.W_data_B   = 1'b0;
    assign bus.R_addr_A   = bus.lk_addr;
    assign bus.rf_ack     = w_rf_ack;
    assign bus.inv_ack    = w_inv_ack;
    assign bus.lk_ack     = bus.R_en_A;
    assign bus.lk_rvalid  = r_lk_rvalid;
    assign bus.lk_bit     = bus.R_data_A;
    assign bus.flush_busy = (r_state == FLUSH);
endmodule

// File: tb/tb_valid_ram_ctrl.sv
// tb_valid_ram_ctrl: directed table-driven bench for valid_ram_ctrl at
// DEEPTH=4 with a behavioural 2W/1R valid-bit RAM (port-B drop on same
// address, write-through on read).
module tb_valid_ram_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    valid_ram_ctrl_if #(.DEEPTH(4)) bus ();
    valid_ram_ctrl #(.DEEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // RAM model: starts all-ones so a missing sweep is visible.
    logic [15:0] mem = '1;
    logic        rdata = 1'b0;
    always @(posedge clk) begin
        if (bus.W_en_A) mem[bus.W_addr_A] = bus.W_data_A;
        if (bus.W_en_B && !(bus.W_en_A && bus.W_addr_A == bus.W_addr_B))
            mem[bus.W_addr_B] = bus.W_data_B;
        if (bus.R_en_A) rdata <= mem[bus.R_addr_A];
    end
    assign bus.R_data_A = rdata;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.flush_req = 1'b0;
        bus.rf_req = 1'b0;  bus.rf_addr = '0;
        bus.inv_req = 1'b0; bus.inv_addr = '0;
        bus.lk_req = 1'b0;  bus.lk_addr = '0;
    endtask

    // Checks one full sweep starting at cnt=0, with refill/lookup/invalidate
    // requests held high to prove they are refused or discarded.
    task automatic sweep_check(input string tag);
        bus.rf_req = 1'b1;  bus.rf_addr = 4'd4;
        bus.lk_req = 1'b1;  bus.lk_addr = 4'd1;
        bus.inv_req = 1'b1; bus.inv_addr = 4'd4;
        for (int i = 0; i < 8; i++) begin
            #1;
            check({tag, " busy"},   {7'd0, bus.flush_busy}, 8'd1);
            check({tag, " enA"},    {7'd0, bus.W_en_A}, 8'd1);
            check({tag, " addrA"},  {4'd0, bus.W_addr_A}, 8'(i));
            check({tag, " dataA"},  {7'd0, bus.W_data_A}, 8'd0);
            check({tag, " enB"},    {7'd0, bus.W_en_B}, 8'd1);
            check({tag, " addrB"},  {4'd0, bus.W_addr_B}, 8'(i + 8));
            check({tag, " dataB"},  {7'd0, bus.W_data_B}, 8'd0);
            check({tag, " rf_ack"}, {7'd0, bus.rf_ack}, 8'd0);
            check({tag, " lk_ack"}, {7'd0, bus.lk_ack}, 8'd0);
            check({tag, " inv_ack"},{7'd0, bus.inv_ack}, 8'd1);
            step();
        end
        idle_inputs();
        #1;
        check({tag, " busy end"}, {7'd0, bus.flush_busy}, 8'd0);
    endtask

    task automatic lookup(input logic [3:0] a, input logic exp_bit, input string name);
        bus.lk_req = 1'b1; bus.lk_addr = a;
        #1;
        check({name, " ack"}, {7'd0, bus.lk_ack}, 8'd1);
        step();
        bus.lk_req = 1'b0;
        check({name, " rvalid"}, {7'd0, bus.lk_rvalid}, 8'd1);
        check({name, " bit"}, {7'd0, bus.lk_bit}, {7'd0, exp_bit});
    endtask

    typedef struct {
        logic rf; logic [3:0] rfa;
        logic inv; logic [3:0] inva;
        logic lk; logic [3:0] lka;
        logic e_ena; logic [3:0] e_wa; logic e_da;
        logic e_enb; logic [3:0] e_wb;
        logic e_rfack; logic e_invack; logic e_lkack;
        logic e_bit;
    } vec_t;

    vec_t vec [11];

    initial begin
        vec[0]  = '{0,0, 0,0, 1,5,  0,0,0,  0,0, 0,0,1, 0};
        vec[1]  = '{1,3, 0,0, 0,0,  1,3,1,  0,0, 1,0,0, 0};
        vec[2]  = '{0,0, 0,0, 1,3,  0,0,0,  0,0, 0,0,1, 1};
        vec[3]  = '{1,6, 1,6, 0,0,  1,6,0,  0,0, 1,1,0, 0};
        vec[4]  = '{0,0, 0,0, 1,6,  0,0,0,  0,0, 0,0,1, 0};
        vec[5]  = '{1,2, 1,9, 1,2,  1,2,1,  1,9, 1,1,1, 1};
        vec[6]  = '{0,0, 0,0, 1,9,  0,0,0,  0,0, 0,0,1, 0};
        vec[7]  = '{1,1, 1,3, 1,3,  1,1,1,  1,3, 1,1,1, 0};
        vec[8]  = '{1,12,0,0, 1,1,  1,12,1, 0,0, 1,0,1, 1};
        vec[9]  = '{0,0, 0,0, 1,12, 0,0,0,  0,0, 0,0,1, 1};
        vec[10] = '{0,0, 0,0, 0,0,  0,0,0,  0,0, 0,0,0, 0};

        idle_inputs();
        bus.lk_req = 1'b1; bus.rf_req = 1'b1;
        #3;
        check("rst busy",   {7'd0, bus.flush_busy}, 8'd1);
        check("rst enA",    {7'd0, bus.W_en_A}, 8'd0);
        check("rst enB",    {7'd0, bus.W_en_B}, 8'd0);
        check("rst lk_ack", {7'd0, bus.lk_ack}, 8'd0);
        check("rst rvalid", {7'd0, bus.lk_rvalid}, 8'd0);
        step();
        rst_n = 1'b1;
        sweep_check("sweep0");
        lookup(4'd5, 1'b0, "post-sweep lk5");

        for (int i = 0; i < 11; i++) begin
            bus.rf_req = vec[i].rf;   bus.rf_addr = vec[i].rfa;
            bus.inv_req = vec[i].inv; bus.inv_addr = vec[i].inva;
            bus.lk_req = vec[i].lk;   bus.lk_addr = vec[i].lka;
            #1;
            check($sformatf("v%0d enA", i), {7'd0, bus.W_en_A}, {7'd0, vec[i].e_ena});
            if (vec[i].e_ena) begin
                check($sformatf("v%0d addrA", i), {4'd0, bus.W_addr_A}, {4'd0, vec[i].e_wa});
                check($sformatf("v%0d dataA", i), {7'd0, bus.W_data_A}, {7'd0, vec[i].e_da});
            end
            check($sformatf("v%0d enB", i), {7'd0, bus.W_en_B}, {7'd0, vec[i].e_enb});
            if (vec[i].e_enb) begin
                check($sformatf("v%0d addrB", i), {4'd0, bus.W_addr_B}, {4'd0, vec[i].e_wb});
                check($sformatf("v%0d dataB", i), {7'd0, bus.W_data_B}, 8'd0);
            end
            check($sformatf("v%0d rf_ack", i),  {7'd0, bus.rf_ack},  {7'd0, vec[i].e_rfack});
            check($sformatf("v%0d inv_ack", i), {7'd0, bus.inv_ack}, {7'd0, vec[i].e_invack});
            check($sformatf("v%0d lk_ack", i),  {7'd0, bus.lk_ack},  {7'd0, vec[i].e_lkack});
            check($sformatf("v%0d busy", i),    {7'd0, bus.flush_busy}, 8'd0);
            step();
            check($sformatf("v%0d rvalid", i), {7'd0, bus.lk_rvalid}, {7'd0, vec[i].e_lkack});
            if (vec[i].e_lkack)
                check($sformatf("v%0d bit", i), {7'd0, bus.lk_bit}, {7'd0, vec[i].e_bit});
        end
        idle_inputs();

        // Flush pulse: lookup in the same cycle is still served under IDLE.
        bus.flush_req = 1'b1;
        bus.lk_req = 1'b1; bus.lk_addr = 4'd1;
        #1;
        check("flush-cycle lk_ack", {7'd0, bus.lk_ack}, 8'd1);
        check("flush-cycle busy",   {7'd0, bus.flush_busy}, 8'd0);
        step();
        bus.flush_req = 1'b0;
        check("flush-cycle bit", {7'd0, bus.lk_bit}, 8'd1);
        sweep_check("sweep1");
        lookup(4'd1, 1'b0, "after flush lk1");
        lookup(4'd12, 1'b0, "after flush lk12");

        // Reset asserted at sweep cycle 5, then a full restarted sweep.
        bus.flush_req = 1'b1;
        step();
        bus.flush_req = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("mid addrA", {4'd0, bus.W_addr_A}, 8'd5);
        bus.lk_req = 1'b1;
        rst_n = 1'b0;
        #1;
        check("mid-rst enA",   {7'd0, bus.W_en_A}, 8'd0);
        check("mid-rst enB",   {7'd0, bus.W_en_B}, 8'd0);
        check("mid-rst lkack", {7'd0, bus.lk_ack}, 8'd0);
        check("mid-rst busy",  {7'd0, bus.flush_busy}, 8'd1);
        step();
        check("mid-rst rvalid", {7'd0, bus.lk_rvalid}, 8'd0);
        rst_n = 1'b1;
        sweep_check("sweep2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
